// File: rtl/rv32_io_ctrl_pkg.sv
// Shared register offsets, control-bit positions and byte-lane write helpers
// for the rv32_io_ctrl memory-mapped I/O block.
package rv32_io_pkg;

   localparam logic [2:0] IO_OFF_LED    = 3'd0;
   localparam logic [2:0] IO_OFF_IN     = 3'd1;
   localparam logic [2:0] IO_OFF_EDGE   = 3'd2;
   localparam logic [2:0] IO_OFF_IRQEN  = 3'd3;
   localparam logic [2:0] IO_OFF_TCOUNT = 3'd4;
   localparam logic [2:0] IO_OFF_TCMP   = 3'd5;
   localparam logic [2:0] IO_OFF_TCTRL  = 3'd6;
   localparam logic [2:0] IO_OFF_ID     = 3'd7;

   localparam int TCTRL_EN_BIT    = 0;
   localparam int TCTRL_AR_BIT    = 1;
   localparam int TCTRL_MATCH_BIT = 2;
   localparam int IRQEN_TIMER_BIT = 31;

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
      logic [31:0] m;
      m = lane_mask(be);
      return (old_val & ~m) | (wdata & m);
   endfunction

   // Write-one-to-clear restricted to the enabled byte lanes.
   function automatic logic [31:0] w1c_apply(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
      return old_val & ~(wdata & lane_mask(be));
   endfunction

endpackage

// File: rtl/rv32_io_ctrl_debounce.sv
// One input channel: 2-FF synchroniser, stability counter, accepted level
// and a single-cycle pulse on an accepted 0->1 change.
module io_debounce
   import rv32_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
)
(
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   always_comb begin
      accept  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d   = '0;
         level_d = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   // Pulse coincides with the level update so EDGE and IN move together.
   assign rise_o  = accept & sync2_q;

endmodule

// File: rtl/rv32_io_ctrl.sv
// Memory-mapped I/O controller: LEDs, debounced inputs with edge capture,
// compare timer with auto-reload, and a level interrupt.
module rv32_io_ctrl
   import rv32_io_pkg::*;
#(
   parameter int          NUM_IN          = 4,
   parameter int          NUM_OUT         = 10,
   parameter int          DEBOUNCE_CYCLES = 1000000,
   parameter logic [31:0] IO_BASE         = 32'h8000_0000,
   parameter logic [31:0] VERSION         = 32'h0001_0000
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [31:2]        io_addr,
   input  logic [31:0]        io_wdata,
   input  logic               io_we,
   input  logic [3:0]         io_be,
   output logic [31:0]        io_rdata,
   input  logic [NUM_IN-1:0]  pushbuttons,
   output logic [NUM_OUT-1:0] leds,
   output logic               irq
);

   localparam logic [31:0] IN_MASK  = 32'((64'd1 << NUM_IN) - 64'd1);
   localparam logic [31:0] LED_MASK = 32'((64'd1 << NUM_OUT) - 64'd1);
   localparam logic [31:0] IE_MASK  = IN_MASK | (32'd1 << IRQEN_TIMER_BIT);

   logic              hit;
   logic [2:0]        off;
   logic              wr;

   logic [31:0]       led_q, led_d;
   logic [31:0]       edge_q, edge_d;
   logic [31:0]       ie_q, ie_d;
   logic [31:0]       tcount_q, tcount_d;
   logic [31:0]       tcmp_q, tcmp_d;
   logic              en_q, en_d;
   logic              ar_q, ar_d;
   logic              match_q, match_d;
   logic              match_set, match_clr;
   logic [31:0]       rdata_q, rdata_d;

   logic [NUM_IN-1:0] level;
   logic [NUM_IN-1:0] rise;

   for (genvar g = 0; g < NUM_IN; g++) begin : g_in
      io_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .pin_i  (pushbuttons[g]),
         .level_o(level[g]),
         .rise_o (rise[g])
      );
   end

   always_comb begin
      hit = (io_addr[31:5] == IO_BASE[31:5]);
      off = io_addr[4:2];
      wr  = io_we & hit;
   end

   always_comb begin
      led_d = led_q;
      ie_d  = ie_q;
      tcmp_d = tcmp_q;
      if (wr && off == IO_OFF_LED)   led_d  = lane_merge(led_q, io_wdata, io_be) & LED_MASK;
      if (wr && off == IO_OFF_IRQEN) ie_d   = lane_merge(ie_q, io_wdata, io_be) & IE_MASK;
      if (wr && off == IO_OFF_TCMP)  tcmp_d = lane_merge(tcmp_q, io_wdata, io_be);

      // A rise landing with a W1C of the same bit keeps the bit set.
      edge_d = edge_q;
      if (wr && off == IO_OFF_EDGE) edge_d = w1c_apply(edge_q, io_wdata, io_be);
      edge_d = (edge_d | 32'(rise)) & IN_MASK;
   end

   always_comb begin
      tcount_d  = tcount_q;
      match_set = 1'b0;
      if (wr && off == IO_OFF_TCOUNT) begin
         tcount_d = lane_merge(tcount_q, io_wdata, io_be);
      end else if (en_q) begin
         if (tcount_q == tcmp_q) begin
            match_set = 1'b1;
            tcount_d  = ar_q ? 32'd0 : tcount_q + 32'd1;
         end else begin
            tcount_d = tcount_q + 32'd1;
         end
      end

      en_d      = en_q;
      ar_d      = ar_q;
      match_clr = 1'b0;
      if (wr && off == IO_OFF_TCTRL && io_be[0]) begin
         en_d      = io_wdata[TCTRL_EN_BIT];
         ar_d      = io_wdata[TCTRL_AR_BIT];
         match_clr = io_wdata[TCTRL_MATCH_BIT];
      end
      match_d = (match_q & ~match_clr) | match_set;
   end

   // Read mux sees pre-write state; the result is registered to match RAM timing.
   always_comb begin
      rdata_d = 32'd0;
      if (hit) begin
         case (off)
            IO_OFF_LED:    rdata_d = led_q;
            IO_OFF_IN:     rdata_d = 32'(level);
            IO_OFF_EDGE:   rdata_d = edge_q;
            IO_OFF_IRQEN:  rdata_d = ie_q;
            IO_OFF_TCOUNT: rdata_d = tcount_q;
            IO_OFF_TCMP:   rdata_d = tcmp_q;
            IO_OFF_TCTRL:  rdata_d = {29'd0, match_q, ar_q, en_q};
            IO_OFF_ID:     rdata_d = VERSION;
            default:       rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q    <= 32'd0;
         edge_q   <= 32'd0;
         ie_q     <= 32'd0;
         tcount_q <= 32'd0;
         tcmp_q   <= 32'd0;
         en_q     <= 1'b0;
         ar_q     <= 1'b0;
         match_q  <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         led_q    <= led_d;
         edge_q   <= edge_d;
         ie_q     <= ie_d;
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         en_q     <= en_d;
         ar_q     <= ar_d;
         match_q  <= match_d;
         rdata_q  <= rdata_d;
      end
   end

   assign io_rdata = rdata_q;
   assign leds     = led_q[NUM_OUT-1:0];
   assign irq      = (|(edge_q & ie_q & IN_MASK)) | (match_q & ie_q[IRQEN_TIMER_BIT]);

endmodule
